vga_scan_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 32 +++
 rtl/pix_clk_en.sv | 34 +++
 rtl/vga_scan_gen.sv | 124 ++++++++++++
 tb/tb_vga_scan_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing defaults, coordinate widths and sync polarity types
// for the scan generator and the glyph/box renderers.
package vga_pkg;

  localparam int unsigned PIX_X_W = 11;
  localparam int unsigned PIX_Y_W = 10;

  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  // Half-open window test [lo, hi) done at full integer width.
  function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel clock-enable divider: registered one-clk pix_stb_o every CLK_DIV clocks.
module pix_clk_en #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_stb_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_stb_q, pix_stb_d;

  // With CLK_DIV=1 the counter sits at 0 and the strobe stays high.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_stb_d = (div_cnt_q == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pix_stb_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_stb_q <= pix_stb_d;
    end
  end

  assign pix_stb_o = pix_stb_q;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster timing generator: pixel coordinates, syncs and line/frame strobes.
// Optional frame counter output enabled by macro VGA_SCAN_FRAME_CNT_EN.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter sync_pol_e   HS_POL   = SYNC_ACTIVE_LOW,
  parameter sync_pol_e   VS_POL   = SYNC_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PIX_X_W-1:0] pixel_x,
  output logic [PIX_Y_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_stb,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_SCAN_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [PIX_X_W-1:0] H_LAST = PIX_X_W'(HT - 1);
  localparam logic [PIX_Y_W-1:0] V_LAST = PIX_Y_W'(VT - 1);
  localparam logic HS_ACT = logic'(HS_POL);
  localparam logic VS_ACT = logic'(VS_POL);

  if ((HT > 2048) || (VT > 1024) || (CLK_DIV < 1)) begin : g_bad_timing
    $error("vga_scan_gen: H_TOTAL must be <=2048, V_TOTAL <=1024, CLK_DIV >=1");
  end

  logic               stb;
  logic               h_wrap, v_last;
  logic [PIX_X_W-1:0] h_q, h_d;
  logic [PIX_Y_W-1:0] v_q, v_d;
  logic               video_on_q, video_on_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               line_start_q, frame_start_q;

  pix_clk_en #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_clk_en (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_stb_o(stb)
  );

  // Syncs and video_on are derived from next-state coordinates so they
  // change on the same edge as pixel_x/pixel_y.
  always_comb begin
    h_wrap = stb && (h_q == H_LAST);
    v_last = (v_q == V_LAST);
    h_d    = h_q;
    v_d    = v_q;
    if (stb) h_d = h_wrap ? '0 : h_q + 1'b1;
    if (h_wrap) v_d = v_last ? '0 : v_q + 1'b1;
    video_on_d = (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
    hsync_d    = in_window(32'(h_d), HS_START, HS_END) ? HS_ACT : ~HS_ACT;
    vsync_d    = in_window(32'(v_d), VS_START, VS_END) ? VS_ACT : ~VS_ACT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_last;
    end
  end

`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (h_wrap && v_last) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_stb     = stb;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: default 640x480 line timing, a tiny
// CLK_DIV=1 raster traced cycle by cycle, and a CLK_DIV=3 raster for frame timing.
module tb_vga_scan_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b0, rst_b_n = 1'b0, rst_c_n = 1'b0;

  logic [10:0] a_x, b_x, c_x;
  logic [9:0]  a_y, b_y, c_y;
  logic a_vo, a_hs, a_vs, a_ps, a_ls, a_fs;
  logic b_vo, b_hs, b_vs, b_ps, b_ls, b_fs;
  logic c_vo, c_hs, c_vs, c_ps, c_ls, c_fs;
`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc, c_fc;
`endif

  vga_scan_gen #(.CLK_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .pixel_x(a_x), .pixel_y(a_y), .video_on(a_vo),
    .hsync(a_hs), .vsync(a_vs), .pix_stb(a_ps), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_SCAN_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_scan_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .pixel_x(b_x), .pixel_y(b_y), .video_on(b_vo),
    .hsync(b_hs), .vsync(b_vs), .pix_stb(b_ps), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_SCAN_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  vga_scan_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_c_n), .pixel_x(c_x), .pixel_y(c_y), .video_on(c_vo),
    .hsync(c_hs), .vsync(c_vs), .pix_stb(c_ps), .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_SCAN_FRAME_CNT_EN
    , .frame_cnt(c_fc)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          fs_k[$];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tiny raster: after edge k the scan has advanced k-1 pixels (7 x 6 total).
  task automatic trace_b(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      int p, ex, ey;
      logic [31:0] expv, gotv;
      tick();
      p  = k - 1;
      ex = p % 7;
      ey = (p / 7) % 6;
      expv = {5'd0, 11'(ex), 10'(ey), logic'(ex < 4 && ey < 3), logic'(ex != 5),
              logic'(ey != 4), 1'b1, logic'(k > 1 && ex == 0),
              logic'(k > 1 && ex == 0 && ey == 0)};
      gotv = {5'd0, b_x, b_y, b_vo, b_hs, b_vs, b_ps, b_ls, b_fs};
      check_vec($sformatf("%s_k%0d", tag, k), gotv, expv);
      if (b_fs) fs_k.push_back(k);
    end
  endtask

  initial begin
    int hs_cyc, hs_min, hs_max, vo_bad, prev_x, ncyc, nstb, vs_min, vs_max, vs_bad;
    logic seen;

    // ---------------- default timing, CLK_DIV=2 ----------------
    repeat (3) @(posedge clk);
    #1;
    check_vec("a_rst", {5'd0, a_x, a_y, a_vo, a_hs, a_vs, a_ps, a_ls, a_fs},
              {5'd0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_a_n = 1'b1;
    tick();
    check_vec("a_clk1", {a_x, a_y, a_vo, a_hs, a_vs, a_ps, a_ls, a_fs},
              {11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    check_vec("a_clk2_stb", {a_x, a_ps}, {11'd0, 1'b1});
    tick();
    check_vec("a_clk3_x", {a_x, a_ps}, {11'd1, 1'b0});

    hs_cyc = 0; hs_min = 9999; hs_max = -1; vo_bad = 0; prev_x = 1; seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (!a_hs) begin
        hs_cyc++;
        if (int'(a_x) < hs_min) hs_min = int'(a_x);
        if (int'(a_x) > hs_max) hs_max = int'(a_x);
      end
      if (a_vo !== (a_x < 11'd640 && a_y < 10'd480)) vo_bad++;
      if (a_ls) begin seen = 1'b1; break; end
      prev_x = int'(a_x);
    end
    check_vec("a_line_seen", 32'(seen), 32'd1);
    check_vec("a_hs_cycles", hs_cyc, 32'd192);
    check_vec("a_hs_first", hs_min, 32'd656);
    check_vec("a_hs_last", hs_max, 32'd751);
    check_vec("a_video_on", vo_bad, 32'd0);
    check_vec("a_wrap_from", prev_x, 32'd799);
    check_vec("a_wrap_to", {a_x, a_y}, {11'd0, 10'd1});

    ncyc = 0; seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      ncyc++;
      if (a_ls) begin seen = 1'b1; break; end
    end
    check_vec("a_line_period", ncyc, 32'd1600);
    check_vec("a_line2_y", {a_x, a_y}, {11'd0, 10'd2});
    tick();
    check_vec("a_ls_one_clk", 32'(a_ls), 32'd0);

    // ---------------- tiny raster, CLK_DIV=1 ----------------
    @(negedge clk);
    rst_b_n = 1'b1;
    trace_b(90, "b_trace");
    check_vec("b_fs_count", fs_k.size(), 32'd2);
    if (fs_k.size() >= 2) check_vec("b_frame_period", fs_k[1] - fs_k[0], 32'd42);

    #2;
    rst_b_n = 1'b0;
    #1;
    check_vec("b_async_rst", {5'd0, b_x, b_y, b_vo, b_hs, b_vs, b_ps, b_ls, b_fs},
              {5'd0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    repeat (3) tick();
    check_vec("b_rst_hold", {5'd0, b_x, b_y, b_vo, b_hs, b_vs, b_ps, b_ls, b_fs},
              {5'd0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_b_n = 1'b1;
    trace_b(50, "b_restart");

    // ---------------- medium raster, CLK_DIV=3: 15 x 9 ----------------
    @(negedge clk);
    rst_c_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (c_fs) begin seen = 1'b1; break; end
    end
    check_vec("c_fs1_seen", 32'(seen), 32'd1);
    ncyc = 0; nstb = 0; vs_min = 9999; vs_max = -1; vs_bad = 0; seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      ncyc++;
      if (c_fs) begin seen = 1'b1; break; end
      if (c_ps) nstb++;
      if (!c_vs) begin
        if (int'(c_y) < vs_min) vs_min = int'(c_y);
        if (int'(c_y) > vs_max) vs_max = int'(c_y);
      end
      if (c_vs !== !(c_y == 10'd6 || c_y == 10'd7)) vs_bad++;
    end
    check_vec("c_fs2_seen", 32'(seen), 32'd1);
    check_vec("c_frame_clks", ncyc, 32'd405);
    check_vec("c_frame_stb", nstb, 32'd135);
    check_vec("c_vs_first", vs_min, 32'd6);
    check_vec("c_vs_last", vs_max, 32'd7);
    check_vec("c_vs_window", vs_bad, 32'd0);
    check_vec("c_fs_coinc", {c_x, c_y, c_ls}, {11'd0, 10'd0, 1'b1});
    tick();
    check_vec("c_fs_one_clk", {c_fs, c_ls}, 2'b00);

`ifdef VGA_SCAN_FRAME_CNT_EN
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (c_fs) begin seen = 1'b1; break; end
    end
    check_vec("c_fc_3", c_fc, 32'd3);
    #1;
    force dut_c.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_c.frame_cnt_q;
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (c_fs) begin seen = 1'b1; break; end
    end
    check_vec("c_fc_wrap_seen", 32'(seen), 32'd1);
    check_vec("c_fc_wrap", c_fc, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
